// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store controller
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, strobes, load extension and alignment check
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    case (addr_lo)
      2'd0:    rbyte = rdata_in[7:0];
      2'd1:    rbyte = rdata_in[15:8];
      2'd2:    rbyte = rdata_in[23:16];
      default: rbyte = rdata_in[31:24];
    endcase
    rhalf = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];

    wstrb      = 4'b0000;
    wdata_out  = wdata_in;
    rdata_out  = rdata_in;
    misaligned = 1'b0;
    case (size)
      SZ_B, SZ_BU: begin
        wstrb     = STRB_B << addr_lo;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = {{24{(size == SZ_B) & rbyte[7]}}, rbyte};
      end
      SZ_H, SZ_HU: begin
        wstrb      = STRB_H << {addr_lo[1], 1'b0};
        wdata_out  = {2{wdata_in[15:0]}};
        rdata_out  = {{16{(size == SZ_H) & rhalf[15]}}, rhalf};
        misaligned = addr_lo[0];
      end
      SZ_W: begin
        wstrb      = STRB_W;
        misaligned = |addr_lo;
      end
      // Reserved funct3 codes are rejected the same way as misaligned accesses.
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store initiator toward data memory
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_wr,
  input  logic [2:0]        ex_size,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_done,
  output logic [DATA_W-1:0] ex_rdata,
  output logic              ex_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  lsu_state_e       state;
  logic [2:0]       size_q;
  logic [1:0]       addr_lo_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        req_mis;
  logic [31:0] req_rdata_unused;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_wstrb_unused;
  logic [31:0] rsp_wdata_unused;
  logic        rsp_mis_unused;

  // Request side works on the live execute inputs; response side on the latched op.
  lsu_align u_align_req (
    .size       (ex_size),
    .addr_lo    (ex_addr[1:0]),
    .wdata_in   (ex_wdata),
    .rdata_in   (mem_rdata),
    .wstrb      (req_wstrb),
    .wdata_out  (req_wdata),
    .rdata_out  (req_rdata_unused),
    .misaligned (req_mis)
  );

  lsu_align u_align_rsp (
    .size       (size_q),
    .addr_lo    (addr_lo_q),
    .wdata_in   (32'h0),
    .rdata_in   (mem_rdata),
    .wstrb      (rsp_wstrb_unused),
    .wdata_out  (rsp_wdata_unused),
    .rdata_out  (rsp_rdata),
    .misaligned (rsp_mis_unused)
  );

  assign cnt_nxt = cnt + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ex_ready  <= 1'b1;
      ex_done   <= 1'b0;
      ex_err    <= 1'b0;
      ex_rdata  <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      size_q    <= SZ_B;
      addr_lo_q <= 2'b00;
      cnt       <= '0;
    end else begin
      ex_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && ex_ready) begin
            ex_ready  <= 1'b0;
            size_q    <= ex_size;
            addr_lo_q <= ex_addr[1:0];
            if (req_mis) begin
              state    <= RESP;
              ex_done  <= 1'b1;
              ex_err   <= 1'b1;
              ex_rdata <= '0;
            end else begin
              state     <= REQ;
              mem_valid <= 1'b1;
              mem_wr    <= ex_wr;
              mem_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= req_wdata;
              mem_wstrb <= req_wstrb;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            cnt       <= '0;
            if (mem_wr) begin
              state    <= RESP;
              ex_done  <= 1'b1;
              ex_err   <= 1'b0;
              ex_rdata <= '0;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            state    <= RESP;
            ex_done  <= 1'b1;
            ex_err   <= 1'b0;
            ex_rdata <= rsp_rdata;
          end else begin
            cnt <= cnt_nxt;
            if (TIMEOUT != 0 && cnt_nxt == CNT_W'(TIMEOUT)) begin
              state    <= RESP;
              ex_done  <= 1'b1;
              ex_err   <= 1'b1;
              ex_rdata <= '0;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          ex_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid, ex_ready, ex_wr, ex_done, ex_err;
  logic [2:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata, ex_rdata;
  logic        mem_valid, mem_ready, mem_wr, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wr(ex_wr), .ex_size(ex_size),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_done(ex_done), .ex_rdata(ex_rdata),
    .ex_err(ex_err), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_mis(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      3'b010:         return a != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      3'b000, 3'b100: return 4'(1 << a);
      3'b001, 3'b101: return 4'(3 << (a & 2'b10));
      default:        return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [31:0] wd);
    case (sz)
      3'b000, 3'b100: return wd[7:0] * 32'h01010101;
      3'b001, 3'b101: return wd[15:0] * 32'h00010001;
      default:        return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [1:0] a,
                                             input logic [31:0] rd);
    int unsigned v;
    case (sz)
      3'b000, 3'b100: begin
        v = (rd >> (8 * a)) % 256;
        if (sz == 3'b000 && v >= 128) v = v + 32'hFFFFFF00;
      end
      3'b001, 3'b101: begin
        v = (rd >> (8 * (a & 2'b10))) % 65536;
        if (sz == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // One complete operation; rdly = cycles of mem_ready low, vdly = cycles before rvalid.
  task automatic do_op(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int rdly, input int vdly);
    bit          mis;
    logic [31:0] exp_r;
    mis   = model_mis(sz, addr[1:0]);
    exp_r = (mis || wr) ? 32'h0 : model_load(sz, addr[1:0], rd);
    @(negedge clock);
    chk("idle_ready", ex_ready, 1);
    ex_valid = 1'b1; ex_wr = wr; ex_size = sz; ex_addr = addr; ex_wdata = wd;
    @(negedge clock);
    ex_valid = 1'b0; ex_addr = $urandom; ex_wdata = $urandom;
    if (mis) begin
      chk("mis_done", ex_done, 1);
      chk("mis_err", ex_err, 1);
      chk("mis_rdata", ex_rdata, 0);
      chk("mis_memv", mem_valid, 0);
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        chk("req_valid", mem_valid, 1);
        chk("req_addr", mem_addr, {addr[31:2], 2'b00});
        chk("req_wr", mem_wr, wr);
        chk("req_strb", mem_wstrb, model_strb(sz, addr[1:0]));
        if (wr) chk("req_wdata", mem_wdata, model_wdata(sz, wd));
        chk("req_exready", ex_ready, 0);
        chk("req_done", ex_done, 0);
        mem_ready = (i == rdly);
        @(negedge clock);
      end
      mem_ready = 1'b0;
      if (!wr) begin
        for (int j = 0; j <= vdly; j++) begin
          chk("wait_memv", mem_valid, 0);
          chk("wait_done", ex_done, 0);
          mem_rvalid = (j == vdly);
          mem_rdata  = (j == vdly) ? rd : $urandom;
          @(negedge clock);
        end
        mem_rvalid = 1'b0;
      end
      chk("done", ex_done, 1);
      chk("err", ex_err, 0);
      chk("rdata", ex_rdata, exp_r);
    end
    @(negedge clock);
    chk("done_pulse", ex_done, 0);
    chk("ready_back", ex_ready, 1);
    chk("rdata_hold", ex_rdata, exp_r);
    chk("post_memv", mem_valid, 0);
  endtask

  initial begin
    logic [2:0]  sizes [13];
    logic [31:0] r_addr, r_wd, r_rd;
    sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    ex_valid = 0; ex_wr = 0; ex_size = 0; ex_addr = 0; ex_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clock);
    chk("rst_ready", ex_ready, 1);
    chk("rst_done", ex_done, 0);
    chk("rst_err", ex_err, 0);
    chk("rst_memv", mem_valid, 0);
    chk("rst_memwr", mem_wr, 0);
    chk("rst_rdata", ex_rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_strb", mem_wstrb, 0);
    reset_n = 1'b1;

    do_op(1'b1, 3'b000, 32'h80000003, 32'h000000AB, 32'h0, 0, 0);
    do_op(1'b0, 3'b001, 32'h80000002, 32'h0, 32'h80011234, 0, 0);
    do_op(1'b0, 3'b101, 32'h80000002, 32'h0, 32'h80011234, 0, 0);
    do_op(1'b1, 3'b010, 32'h80000010, 32'hDEADBEEF, 32'h0, 5, 0);
    do_op(1'b0, 3'b010, 32'h80000006, 32'h0, 32'h0, 0, 0);
    do_op(1'b0, 3'b001, 32'h80000001, 32'h0, 32'h0, 0, 0);

    // Load that never gets read data: must time out after TMO WAIT_R cycles.
    @(negedge clock);
    ex_valid = 1'b1; ex_wr = 1'b0; ex_size = 3'b010; ex_addr = 32'h80000020;
    @(negedge clock);
    ex_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      chk("tmo_wait", ex_done, 0);
      @(negedge clock);
    end
    chk("tmo_done", ex_done, 1);
    chk("tmo_err", ex_err, 1);
    chk("tmo_rdata", ex_rdata, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clock);
    chk("tmo_stray1", ex_done, 0);
    @(negedge clock);
    chk("tmo_stray2", ex_done, 0);
    mem_rvalid = 1'b0;
    do_op(1'b0, 3'b100, 32'h80000021, 32'h0, 32'h0000F700, 0, 1);

    // Asynchronous reset while waiting for read data.
    @(negedge clock);
    ex_valid = 1'b1; ex_wr = 1'b0; ex_size = 3'b010; ex_addr = 32'h80000040;
    @(negedge clock);
    ex_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    @(negedge clock);
    chk("rstw_addr_pre", mem_addr, 32'h80000040);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_ready", ex_ready, 1);
    chk("rstw_addr", mem_addr, 0);
    chk("rstw_strb", mem_wstrb, 0);
    chk("rstw_memv", mem_valid, 0);
    chk("rstw_done", ex_done, 0);
    @(negedge clock);
    reset_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clock);
    chk("rstw_stray", ex_done, 0);
    mem_rvalid = 1'b0;
    @(negedge clock);
    chk("rstw_stray2", ex_done, 0);
    chk("rstw_ready2", ex_ready, 1);

    for (int n = 0; n < 80; n++) begin
      r_addr = $urandom; r_wd = $urandom; r_rd = $urandom;
      do_op(1'($urandom_range(0, 1)), sizes[$urandom_range(0, 12)], r_addr, r_wd, r_rd,
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
